// File: rtl/dspl_rx_nexysa7.sv
// Receive side of the 8-digit multiplexed 7-seg scan: rebuilds d1..d8 = {en, hex[3:0], dp} from an/dec_cat.
// Optional saturating error counter on err_cnt: define DSPL_RX_ERR_CNT_EN.
module dspl_rx_nexysa7 #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] dec_cat,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       timeout,
    output logic [7:0] err_cnt
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // {match, hex} for an active-low abcdefg pattern
    function automatic logic [4:0] seg_decode(input logic [6:0] segs);
        case (segs)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b1100000: return {1'b1, 4'hB};
            7'b0110001: return {1'b1, 4'hC};
            7'b1000010: return {1'b1, 4'hD};
            7'b0110000: return {1'b1, 4'hE};
            7'b0111000: return {1'b1, 4'hF};
            default:    return 5'b0;
        endcase
    endfunction

    function automatic logic one_hot_low(input logic [7:0] a);
        logic [7:0] x;
        x = ~a;
        return (x != 8'h00) && ((x & (x - 8'd1)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_idx(input logic [7:0] a);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++)
            if (!a[k]) r = 3'(k);
        return r;
    endfunction

    logic [7:0]    an_p0, an_p1, an_p2, cat_p0, cat_p1, cat_p2;
    logic [SW-1:0] stab_cnt;
    logic          in_chg, an_chg;
    state_t        state, state_nxt;
    logic          err_lock, cap_go, anode_err;

    assign in_chg = {an_p1, cat_p1} != {an_p2, cat_p2};
    assign an_chg = an_p1 != an_p2;

    // Stage p0/p1: two-flop synchronisers; p2: previous synced value for stability tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_p0    <= 8'hFF;
            an_p1    <= 8'hFF;
            an_p2    <= 8'hFF;
            cat_p0   <= 8'hFF;
            cat_p1   <= 8'hFF;
            cat_p2   <= 8'hFF;
            stab_cnt <= '0;
        end else begin
            an_p0  <= an;
            an_p1  <= an_p0;
            an_p2  <= an_p1;
            cat_p0 <= dec_cat;
            cat_p1 <= cat_p0;
            cat_p2 <= cat_p1;
            if (in_chg)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + SW'(1);
        end
    end

    // err_lock stops a stuck multi-anode pattern from re-triggering until the anodes move
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            err_lock <= 1'b0;
        end else begin
            state <= state_nxt;
            if (anode_err)
                err_lock <= 1'b1;
            else if (an_chg)
                err_lock <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_go    = 1'b0;
        anode_err = 1'b0;
        case (state)
            IDLE:
                if (an_p1 != 8'hFF && !err_lock) state_nxt = SETTLE;
            SETTLE:
                if (an_p1 == 8'hFF) begin
                    state_nxt = IDLE;
                end else if (stab_cnt == STAB_MAX && !in_chg) begin
                    if (one_hot_low(an_p1)) begin
                        cap_go    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        anode_err = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            HOLD:
                if (an_chg) state_nxt = (an_p1 == 8'hFF) ? IDLE : SETTLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    logic [2:0]    cap_idx, last_idx;
    logic [4:0]    dec;
    logic          cap_blank, cap_bad, wrap, tmo_hit, last_vld;
    logic [5:0]    cap_val;
    logic [5:0]    dig [8];
    logic [7:0]    seen;
    logic [TW-1:0] tmo_cnt;

    assign cap_idx   = low_idx(an_p1);
    assign dec       = seg_decode(cat_p1[7:1]);
    assign cap_blank = cat_p1 == 8'hFF;
    assign cap_bad   = !cap_blank && !dec[4];
    assign cap_val   = cap_blank ? 6'b0 : {1'b1, (dec[4] ? dec[3:0] : 4'h0), ~cat_p1[0]};
    assign wrap      = last_vld && (cap_idx <= last_idx);
    assign tmo_hit   = tmo_cnt == TMO_MAX;

    // Stage p3: digit registers, frame tracking and timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) dig[k] <= 6'b0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
            seen        <= 8'h00;
            last_idx    <= 3'd0;
            last_vld    <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            if (cap_go) begin
                for (int k = 0; k < 8; k++)
                    if (wrap && !seen[k]) dig[k] <= 6'b0;
                dig[cap_idx] <= cap_val;
                frame_valid  <= wrap;
                seg_err      <= cap_bad;
                timeout      <= 1'b0;
                tmo_cnt      <= '0;
                seen         <= wrap ? (8'b1 << cap_idx) : (seen | (8'b1 << cap_idx));
                last_idx     <= cap_idx;
                last_vld     <= 1'b1;
            end else if (tmo_hit) begin
                for (int k = 0; k < 8; k++) dig[k] <= 6'b0;
                timeout  <= 1'b1;
                seen     <= 8'h00;
                last_vld <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

`ifdef DSPL_RX_ERR_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_cnt <= 8'h00;
        else if (((cap_go && cap_bad) || anode_err) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
`endif

    assign d1 = dig[0];
    assign d2 = dig[1];
    assign d3 = dig[2];
    assign d4 = dig[3];
    assign d5 = dig[4];
    assign d6 = dig[5];
    assign d7 = dig[6];
    assign d8 = dig[7];
endmodule
